reservation_station_as: RTL and testbench

//  Add/sub reservation station: the consumer end of the CDB. Accepts issued add/sub instructions,

---
 rtl/reservation_station_as_pkg.sv | 33 +++
 rtl/reservation_station_as_if.sv | 45 ++++
 rtl/reservation_station_as_rs_entry.sv | 86 ++++++++
 rtl/reservation_station_as.sv | 133 +++++++++++++
 tb/tb_reservation_station_as.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_as_pkg.sv
// Shared Tomasulo definitions for the add/sub reservation station:
// widths, CDB field layout, entry states and the per-entry payload.
package reservation_station_as_pkg;

    localparam int DATA_W  = 16;
    localparam int TAG_W   = 4;
    localparam int RD_W    = 3;
    localparam int CI_W    = 10;
    localparam int CDB_W   = 20;
    localparam int TAG_HI  = 19;
    localparam int TAG_LO  = 16;
    localparam int DATA_HI = 15;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } rs_state_e;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
        logic [RD_W-1:0]   rd;
        logic [CI_W-1:0]   clk_inst;
    } rs_fields_t;

endpackage

// File: rtl/reservation_station_as_if.sv
// Issue, CDB and dispatch bundle of the add/sub reservation station.
// master = issue stage / CDB / FU side, slave = the station itself.
interface reservation_station_as_if;
    import reservation_station_as_pkg::*;

    logic              issue_valid;
    logic              issue_ready;
    logic              issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [RD_W-1:0]   issue_rd;
    logic [CI_W-1:0]   issue_clk_inst;
    logic [TAG_W-1:0]  issue_tag;
    logic [CDB_W-1:0]  CDB;
    logic              cdb_valid;
    logic              disp_valid;
    logic              disp_ready;
    logic              disp_op;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [RD_W-1:0]   disp_rd;
    logic [TAG_W-1:0]  disp_tag;
    logic [CI_W-1:0]   disp_clk_inst;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk,
        output issue_qj, issue_qk, issue_rd, issue_clk_inst,
        output CDB, cdb_valid, disp_ready,
        input  issue_ready, issue_tag,
        input  disp_valid, disp_op, disp_a, disp_b,
        input  disp_rd, disp_tag, disp_clk_inst
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk,
        input  issue_qj, issue_qk, issue_rd, issue_clk_inst,
        input  CDB, cdb_valid, disp_ready,
        output issue_ready, issue_tag,
        output disp_valid, disp_op, disp_a, disp_b,
        output disp_rd, disp_tag, disp_clk_inst
    );

endinterface

// File: rtl/reservation_station_as_rs_entry.sv
// One reservation entry: FREE -> WAIT|READY -> EXEC -> FREE,
// snooping the CDB for pending operands and for its own release tag.
module reservation_station_as_rs_entry
    import reservation_station_as_pkg::*;
#(
    parameter logic [TAG_W-1:0] MY_TAG = 4'd1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              alloc,
    input  rs_fields_t        alloc_fields,
    input  logic              dispatch,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output rs_state_e         state,
    output rs_fields_t        fields
);

    rs_state_e  state_nxt;
    rs_fields_t fields_nxt;
    logic       hit_j;
    logic       hit_k;
    logic       own_hit;

    assign hit_j   = cdb_valid && (fields.qj != TAG_NONE) && (fields.qj == cdb_tag);
    assign hit_k   = cdb_valid && (fields.qk != TAG_NONE) && (fields.qk == cdb_tag);
    assign own_hit = cdb_valid && (cdb_tag == MY_TAG);

    // Next state and payload: allocate, capture operands, dispatch, release.
    always_comb begin
        state_nxt  = state;
        fields_nxt = fields;
        unique case (state)
            ST_FREE: begin
                if (alloc) begin
                    fields_nxt = alloc_fields;
                    if ((alloc_fields.qj == TAG_NONE) &&
                        (alloc_fields.qk == TAG_NONE)) begin
                        state_nxt = ST_READY;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (hit_j) begin
                    fields_nxt.vj = cdb_data;
                    fields_nxt.qj = TAG_NONE;
                end
                if (hit_k) begin
                    fields_nxt.vk = cdb_data;
                    fields_nxt.qk = TAG_NONE;
                end
                if ((fields_nxt.qj == TAG_NONE) &&
                    (fields_nxt.qk == TAG_NONE)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (dispatch) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The tag stays reserved until its own result is broadcast.
                if (own_hit) begin
                    state_nxt = ST_FREE;
                end
            end
            default: state_nxt = ST_FREE;
        endcase
    end

    // State and payload registers; clear drops the entry and its tags.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= ST_FREE;
            fields <= '0;
        end else begin
            state  <= state_nxt;
            fields <= fields_nxt;
        end
    end

endmodule

// File: rtl/reservation_station_as.sv
// Add/sub reservation station: allocates the lowest free entry on issue,
// bypasses a same-cycle CDB operand, and dispatches the oldest ready entry.
module reservation_station_as
    import reservation_station_as_pkg::*;
#(
    parameter int N_ENTRIES = 3,
    parameter int BASE_TAG  = 1
) (
    input logic CLK,
    input logic CLR,
    reservation_station_as_if.slave bus
);

    logic [TAG_W-1:0]  snoop_tag;
    logic [DATA_W-1:0] snoop_data;
    logic              bypass_j;
    logic              bypass_k;
    rs_fields_t        new_fields;

    rs_state_e         st [N_ENTRIES];
    rs_fields_t        fl [N_ENTRIES];

    logic [N_ENTRIES-1:0] alloc_oh;
    logic [N_ENTRIES-1:0] alloc;
    logic [N_ENTRIES-1:0] disp_oh;
    logic [N_ENTRIES-1:0] dispatch;
    logic                 free_any;
    logic [TAG_W-1:0]     free_tag;

    logic                 ready_any;
    logic                 sel_op;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [RD_W-1:0]      sel_rd;
    logic [TAG_W-1:0]     sel_tag;
    logic [CI_W-1:0]      sel_ci;
    logic                 disp_on;
    logic                 disp_fire;

    assign snoop_tag  = bus.CDB[TAG_HI:TAG_LO];
    assign snoop_data = bus.CDB[DATA_HI:0];

    assign bypass_j = bus.cdb_valid && (bus.issue_qj != TAG_NONE) &&
                      (bus.issue_qj == snoop_tag);
    assign bypass_k = bus.cdb_valid && (bus.issue_qk != TAG_NONE) &&
                      (bus.issue_qk == snoop_tag);

    // Issue payload, with operands resolved by a broadcast in the issue cycle.
    always_comb begin
        new_fields          = '0;
        new_fields.op       = bus.issue_op;
        new_fields.vj       = bypass_j ? snoop_data : bus.issue_vj;
        new_fields.qj       = bypass_j ? TAG_NONE : bus.issue_qj;
        new_fields.vk       = bypass_k ? snoop_data : bus.issue_vk;
        new_fields.qk       = bypass_k ? TAG_NONE : bus.issue_qk;
        new_fields.rd       = bus.issue_rd;
        new_fields.clk_inst = bus.issue_clk_inst;
    end

    // Lowest-index free entry, from registered state only.
    always_comb begin
        alloc_oh = '0;
        free_any = 1'b0;
        free_tag = TAG_NONE;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (!free_any && (st[i] == ST_FREE)) begin
                free_any    = 1'b1;
                alloc_oh[i] = 1'b1;
                free_tag    = TAG_W'(BASE_TAG + i);
            end
        end
    end

    // Oldest ready entry; strict compare keeps ties on the lowest index.
    always_comb begin
        disp_oh   = '0;
        ready_any = 1'b0;
        sel_op    = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        sel_rd    = '0;
        sel_tag   = TAG_NONE;
        sel_ci    = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if ((st[i] == ST_READY) &&
                (fl[i].qj == TAG_NONE) && (fl[i].qk == TAG_NONE) &&
                (!ready_any || (fl[i].clk_inst < sel_ci))) begin
                ready_any  = 1'b1;
                disp_oh    = '0;
                disp_oh[i] = 1'b1;
                sel_op     = fl[i].op;
                sel_a      = fl[i].vj;
                sel_b      = fl[i].vk;
                sel_rd     = fl[i].rd;
                sel_tag    = TAG_W'(BASE_TAG + i);
                sel_ci     = fl[i].clk_inst;
            end
        end
    end

    assign disp_on   = ready_any && !CLR;
    assign disp_fire = disp_on && bus.disp_ready;
    assign alloc     = alloc_oh & {N_ENTRIES{bus.issue_valid && !CLR}};
    assign dispatch  = disp_oh & {N_ENTRIES{disp_fire}};

    assign bus.issue_ready   = free_any && !CLR;
    assign bus.issue_tag     = CLR ? TAG_NONE : free_tag;
    assign bus.disp_valid    = disp_on;
    assign bus.disp_op       = disp_on && sel_op;
    assign bus.disp_a        = disp_on ? sel_a : '0;
    assign bus.disp_b        = disp_on ? sel_b : '0;
    assign bus.disp_rd       = disp_on ? sel_rd : '0;
    assign bus.disp_tag      = disp_on ? sel_tag : TAG_NONE;
    assign bus.disp_clk_inst = disp_on ? sel_ci : '0;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
        reservation_station_as_rs_entry #(
            .MY_TAG(TAG_W'(BASE_TAG + g))
        ) u_entry (
            .clk          (CLK),
            .clr          (CLR),
            .alloc        (alloc[g]),
            .alloc_fields (new_fields),
            .dispatch     (dispatch[g]),
            .cdb_valid    (bus.cdb_valid),
            .cdb_tag      (snoop_tag),
            .cdb_data     (snoop_data),
            .state        (st[g]),
            .fields       (fl[g])
        );
    end

endmodule

// File: tb/tb_reservation_station_as.sv
// Bench for reservation_station_as: directed steps followed by random
// traffic, every cycle compared against a slot-level reference model.
module tb_reservation_station_as;
    import reservation_station_as_pkg::*;

    localparam int N    = 3;
    localparam int BASE = 1;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    always #5 CLK = ~CLK;

    reservation_station_as_if bus ();

    reservation_station_as #(
        .N_ENTRIES (N),
        .BASE_TAG  (BASE)
    ) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    typedef struct packed {
        logic        used;
        logic        sent;
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  qa;
        logic [3:0]  qb;
        logic [2:0]  rd;
        logic [9:0]  age;
    } slot_t;

    slot_t m [N];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_free();
        for (int i = 0; i < N; i++)
            if (!m[i].used) return i;
        return -1;
    endfunction

    function automatic int pick_ready();
        int s = -1;
        for (int i = 0; i < N; i++)
            if (m[i].used && !m[i].sent && m[i].qa == 0 && m[i].qb == 0)
                if (s < 0 || m[i].age < m[s].age) s = i;
        return s;
    endfunction

    task automatic check_model();
        int    f;
        int    s;
        logic  rdy;
        logic  dv;
        slot_t e;
        f   = pick_free();
        s   = pick_ready();
        rdy = !CLR && f >= 0;
        dv  = !CLR && s >= 0;
        e   = '0;
        if (dv) e = m[s];
        chk("issue_ready", 32'(bus.issue_ready), 32'(rdy));
        chk("issue_tag", 32'(bus.issue_tag), rdy ? 32'(BASE + f) : 32'd0);
        chk("disp_valid", 32'(bus.disp_valid), 32'(dv));
        chk("disp_op", 32'(bus.disp_op), 32'(e.op));
        chk("disp_a", 32'(bus.disp_a), 32'(e.a));
        chk("disp_b", 32'(bus.disp_b), 32'(e.b));
        chk("disp_rd", 32'(bus.disp_rd), 32'(e.rd));
        chk("disp_tag", 32'(bus.disp_tag), dv ? 32'(BASE + s) : 32'd0);
        chk("disp_clk_inst", 32'(bus.disp_clk_inst), 32'(e.age));
    endtask

    task automatic update_model();
        int          f;
        int          s;
        slot_t       ns;
        logic [3:0]  t;
        logic [15:0] d;
        if (CLR) begin
            for (int i = 0; i < N; i++) m[i] = '0;
            return;
        end
        f  = pick_free();
        s  = pick_ready();
        t  = bus.CDB[19:16];
        d  = bus.CDB[15:0];
        ns = '0;
        ns.used = 1'b1;
        ns.op   = bus.issue_op;
        ns.a    = bus.issue_vj;
        ns.b    = bus.issue_vk;
        ns.qa   = bus.issue_qj;
        ns.qb   = bus.issue_qk;
        ns.rd   = bus.issue_rd;
        ns.age  = bus.issue_clk_inst;
        if (bus.cdb_valid && ns.qa != 0 && ns.qa == t) begin
            ns.a = d; ns.qa = 0;
        end
        if (bus.cdb_valid && ns.qb != 0 && ns.qb == t) begin
            ns.b = d; ns.qb = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (m[i].used && !m[i].sent && bus.cdb_valid) begin
                if (m[i].qa != 0 && m[i].qa == t) begin
                    m[i].a = d; m[i].qa = 0;
                end
                if (m[i].qb != 0 && m[i].qb == t) begin
                    m[i].b = d; m[i].qb = 0;
                end
            end else if (m[i].used && m[i].sent && bus.cdb_valid &&
                         32'(t) == BASE + i) begin
                m[i] = '0;
            end
        end
        if (s >= 0 && bus.disp_ready) m[s].sent = 1'b1;
        if (bus.issue_valid && f >= 0) m[f] = ns;
    endtask

    task automatic cycle();
        #1;
        check_model();
        @(posedge CLK);
        update_model();
        @(negedge CLK);
    endtask

    task automatic set_issue(input logic op, input logic [15:0] vj,
                             input logic [15:0] vk, input logic [3:0] qj,
                             input logic [3:0] qk, input logic [2:0] rd,
                             input logic [9:0] ci);
        bus.issue_valid    = 1'b1;
        bus.issue_op       = op;
        bus.issue_vj       = vj;
        bus.issue_vk       = vk;
        bus.issue_qj       = qj;
        bus.issue_qk       = qk;
        bus.issue_rd       = rd;
        bus.issue_clk_inst = ci;
    endtask

    task automatic do_reset();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        bus.disp_ready  = 1'b0;
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
    endtask

    initial begin
        logic [3:0] qpick [8];
        logic [3:0] cpick [8];
        qpick = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9};
        cpick = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9};
        for (int i = 0; i < N; i++) m[i] = '0;
        bus.issue_valid    = 1'b0;
        bus.issue_op       = 1'b0;
        bus.issue_vj       = '0;
        bus.issue_vk       = '0;
        bus.issue_qj       = '0;
        bus.issue_qk       = '0;
        bus.issue_rd       = '0;
        bus.issue_clk_inst = '0;
        bus.CDB            = '0;
        bus.cdb_valid      = 1'b0;
        bus.disp_ready     = 1'b0;

        // reset held two cycles, ready the cycle after
        CLR = 1'b1;
        #1 chk("t1_ready_clr", 32'(bus.issue_ready), 32'd0);
        chk("t1_valid_clr", 32'(bus.disp_valid), 32'd0);
        cycle();
        #1 chk("t1_ready_clr2", 32'(bus.issue_ready), 32'd0);
        cycle();
        CLR = 1'b0;
        #1 chk("t1_ready_after", 32'(bus.issue_ready), 32'd1);

        // simple ready issue
        set_issue(1'b0, 16'd5, 16'd7, 4'd0, 4'd0, 3'd1, 10'd3);
        #1 chk("t2_tag", 32'(bus.issue_tag), 32'd1);
        cycle();
        bus.issue_valid = 1'b0;
        #1 chk("t2_valid", 32'(bus.disp_valid), 32'd1);
        chk("t2_a", 32'(bus.disp_a), 32'd5);
        chk("t2_b", 32'(bus.disp_b), 32'd7);
        cycle();
        do_reset();

        // operand captured by a later broadcast
        set_issue(1'b0, 16'd0, 16'd4, 4'd2, 4'd0, 3'd2, 10'd5);
        cycle();
        bus.issue_valid = 1'b0;
        cycle();
        #1 chk("t3_wait", 32'(bus.disp_valid), 32'd0);
        bus.cdb_valid = 1'b1;
        bus.CDB       = {4'd2, 16'h00AA};
        cycle();
        bus.cdb_valid = 1'b0;
        #1 chk("t3_valid", 32'(bus.disp_valid), 32'd1);
        chk("t3_a", 32'(bus.disp_a), 32'h00AA);
        chk("t3_b", 32'(bus.disp_b), 32'd4);
        do_reset();

        // operand captured in the issue cycle
        set_issue(1'b0, 16'd0, 16'd4, 4'd2, 4'd0, 3'd2, 10'd5);
        bus.cdb_valid = 1'b1;
        bus.CDB       = {4'd2, 16'h00AA};
        cycle();
        bus.issue_valid = 1'b0;
        bus.cdb_valid   = 1'b0;
        #1 chk("t3b_valid", 32'(bus.disp_valid), 32'd1);
        chk("t3b_a", 32'(bus.disp_a), 32'h00AA);
        do_reset();

        // age order, full station, reissue of a released tag
        set_issue(1'b0, 16'd9, 16'd1, 4'd0, 4'd0, 3'd1, 10'd9);
        cycle();
        set_issue(1'b0, 16'd4, 16'd1, 4'd0, 4'd0, 3'd2, 10'd4);
        cycle();
        set_issue(1'b0, 16'd6, 16'd1, 4'd0, 4'd0, 3'd3, 10'd6);
        cycle();
        bus.issue_valid = 1'b0;
        bus.disp_ready  = 1'b1;
        #1 chk("t4_first", 32'(bus.disp_clk_inst), 32'd4);
        cycle();
        #1 chk("t4_second", 32'(bus.disp_clk_inst), 32'd6);
        cycle();
        #1 chk("t4_third", 32'(bus.disp_clk_inst), 32'd9);
        cycle();
        bus.disp_ready = 1'b0;
        set_issue(1'b1, 16'd2, 16'd3, 4'd0, 4'd0, 3'd4, 10'd2);
        #1 chk("t4_full", 32'(bus.issue_ready), 32'd0);
        cycle();
        cycle();
        bus.cdb_valid = 1'b1;
        bus.CDB       = {4'd2, 16'h0000};
        #1 chk("t4_full_bcast", 32'(bus.issue_ready), 32'd0);
        cycle();
        bus.cdb_valid = 1'b0;
        #1 chk("t4_ready_again", 32'(bus.issue_ready), 32'd1);
        chk("t4_reissue_tag", 32'(bus.issue_tag), 32'd2);
        cycle();
        bus.issue_valid = 1'b0;
        #1 chk("t4_reissue_disp", 32'(bus.disp_tag), 32'd2);
        cycle();
        do_reset();

        // stall holds outputs; a foreign tag changes nothing
        set_issue(1'b1, 16'h1234, 16'h5678, 4'd0, 4'd0, 3'd5, 10'd7);
        cycle();
        bus.issue_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.cdb_valid = (k == 2);
            bus.CDB       = {4'd7, 16'hBEEF};
            #1 chk("t5_valid", 32'(bus.disp_valid), 32'd1);
            chk("t5_op", 32'(bus.disp_op), 32'd1);
            chk("t5_a", 32'(bus.disp_a), 32'h1234);
            chk("t5_b", 32'(bus.disp_b), 32'h5678);
            chk("t5_rd", 32'(bus.disp_rd), 32'd5);
            chk("t5_tag", 32'(bus.disp_tag), 32'd1);
            chk("t5_ci", 32'(bus.disp_clk_inst), 32'd7);
            cycle();
        end
        bus.cdb_valid = 1'b0;
        do_reset();

        // clear with two waiting and one executing entry
        set_issue(1'b0, 16'd1, 16'd1, 4'd0, 4'd0, 3'd1, 10'd1);
        cycle();
        set_issue(1'b0, 16'd0, 16'd1, 4'd5, 4'd0, 3'd2, 10'd2);
        bus.disp_ready = 1'b1;
        cycle();
        bus.disp_ready = 1'b0;
        set_issue(1'b0, 16'd1, 16'd0, 4'd0, 4'd6, 3'd3, 10'd3);
        cycle();
        bus.issue_valid = 1'b0;
        #1 chk("t6_full", 32'(bus.issue_ready), 32'd0);
        CLR = 1'b1;
        cycle();
        CLR = 1'b0;
        #1 chk("t6_ready", 32'(bus.issue_ready), 32'd1);
        chk("t6_tag", 32'(bus.issue_tag), 32'd1);
        bus.cdb_valid = 1'b1;
        bus.CDB       = {4'd1, 16'h5555};
        cycle();
        bus.cdb_valid = 1'b0;
        #1 chk("t6_ignored_rdy", 32'(bus.issue_ready), 32'd1);
        chk("t6_ignored_valid", 32'(bus.disp_valid), 32'd0);
        cycle();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            CLR                = ($urandom % 64) == 0;
            bus.issue_valid    = 1'($urandom % 2);
            bus.issue_op       = 1'($urandom % 2);
            bus.issue_vj       = 16'($urandom);
            bus.issue_vk       = 16'($urandom);
            bus.issue_qj       = qpick[$urandom % 8];
            bus.issue_qk       = qpick[$urandom % 8];
            bus.issue_rd       = 3'($urandom);
            bus.issue_clk_inst = 10'($urandom % 8);
            bus.cdb_valid      = 1'($urandom % 2);
            bus.CDB            = {cpick[$urandom % 8], 16'($urandom)};
            bus.disp_ready     = ($urandom % 4) != 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
